// File: rtl/lab_arith_pkg.sv
// rtl/lab_arith_pkg.sv - shared types and constants for the bit-serial arithmetic cells
package lab_arith_pkg;

  // Sequencing states shared by the serial arithmetic tops
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Operand width used when a top is instantiated without an override
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - gate-level one-bit full subtractor cell
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  wire x_n;
  wire xy;
  wire xy_n;
  wire nx_and_y;
  wire eq_and_bin;
  wire d_w;
  wire bout_w;

  // Difference bit: x - y - bin modulo 2 is the three-way parity
  xor u_xor_xy  (xy, x, y);
  xor u_xor_d   (d_w, xy, bin);

  // Borrow out when y exceeds x, or when they are equal and a borrow comes in
  not u_not_x   (x_n, x);
  and u_and_nxy (nx_and_y, x_n, y);
  not u_not_xy  (xy_n, xy);
  and u_and_eqb (eq_and_bin, xy_n, bin);
  or  u_or_bout (bout_w, nx_and_y, eq_and_bin);

  assign d    = d_w;
  assign bout = bout_w;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with start/busy/done handshake
module serial_subtractor
  import lab_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             bff;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] res_next;

  // One shared cell handles every bit position; operands shift past it
  full_subtractor u_cell (
    .d    (d),
    .bout (bout),
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bff)
  );

  // New difference bit enters at the top so the LSB lands at bit 0 after WIDTH shifts
  assign res_next = {d, res[WIDTH-1:1]};

  // Sequencer, datapath shift registers and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      bff    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          // FIN is the done cycle; a start here overlaps the pulse with the next capture
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            bff   <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at while bits are in flight
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          bff <= bout;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            diff   <= res_next;
            borrow <= bout;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of the serial subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start5;
  logic [7:0] a;
  logic [7:0] b;
  logic [4:0] a5;
  logic [4:0] b5;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       busy5;
  logic       done5;
  logic [4:0] diff5;
  logic       borrow5;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  serial_subtractor #(.WIDTH(5)) dut5 (
    .clk    (clk),
    .rst    (rst),
    .start  (start5),
    .a      (a5),
    .b      (b5),
    .busy   (busy5),
    .done   (done5),
    .diff   (diff5),
    .borrow (borrow5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, borrow, diff} !== 11'h0)
      $display("FAIL reset_w8: busy/done/borrow/diff=%b/%b/%b/%h required 0/0/0/00", busy, done, borrow, diff);
    else passed++;
    checks++;
    if ({busy5, done5, borrow5, diff5} !== 8'h0)
      $display("FAIL reset_w5: busy/done/borrow/diff=%b/%b/%b/%h required 0/0/0/00", busy5, done5, borrow5, diff5);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    start = 1'b1;
    a = 8'h5A;
    b = 8'h3C;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0;
        a = 8'hFF;
        b = 8'h00;
      end
      if (c <= 8) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0)
          $display("FAIL basic_busy c%0d: busy/done=%b/%b required 1/0", c, busy, done);
        else passed++;
      end else if (c == 9) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b1)
          $display("FAIL basic_done: busy/done=%b/%b required 0/1", busy, done);
        else passed++;
        checks++;
        if (diff !== 8'h1E || borrow !== 1'b0)
          $display("FAIL basic_result: diff/borrow=%h/%b required 1e/0", diff, borrow);
        else passed++;
      end else begin
        checks++;
        if (done !== 1'b0 || diff !== 8'h1E)
          $display("FAIL basic_after: done/diff=%b/%h required 0/1e", done, diff);
        else passed++;
      end
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    logic       vbr [3];
    int         seen;
    va[0] = 8'h00; vb[0] = 8'h01; vd[0] = 8'hFF; vbr[0] = 1'b1;
    va[1] = 8'h80; vb[1] = 8'h7F; vd[1] = 8'h01; vbr[1] = 1'b0;
    va[2] = 8'hA5; vb[2] = 8'hA5; vd[2] = 8'h00; vbr[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      a = va[i];
      b = vb[i];
      seen = 0;
      for (int c = 1; c <= 12 && seen == 0; c++) begin
        tick();
        start = 1'b0;
        if (done === 1'b1) begin
          seen = c;
          checks++;
          if (diff !== vd[i] || borrow !== vbr[i])
            $display("FAIL vector%0d: diff/borrow=%h/%b required %h/%b", i, diff, borrow, vd[i], vbr[i]);
          else passed++;
        end
      end
      checks++;
      if (seen != 9)
        $display("FAIL vector%0d_latency: done at cycle %0d required 9", i, seen);
      else passed++;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [28];
    logic [7:0] vb [28];
    logic [7:0] exp_d;
    logic       exp_b;
    for (int c = 0; c < 28; c++) begin
      va[c] = 8'(c * 37 + 11);
      vb[c] = 8'(c * 91 + 5);
    end
    start = 1'b1;
    a = va[0];
    b = vb[0];
    for (int c = 1; c <= 27; c++) begin
      tick();
      a = va[c];
      b = vb[c];
      checks++;
      if (done !== (c % 9 == 0) || busy !== (c % 9 != 0))
        $display("FAIL b2b_handshake c%0d: busy/done=%b/%b required %b/%b", c, busy, done, (c % 9 != 0), (c % 9 == 0));
      else passed++;
      if (c % 9 == 0) begin
        {exp_b, exp_d} = {1'b0, va[c-9]} - {1'b0, vb[c-9]};
        checks++;
        if (diff !== exp_d || borrow !== exp_b)
          $display("FAIL b2b_result c%0d: diff/borrow=%h/%b required %h/%b", c, diff, borrow, exp_d, exp_b);
        else passed++;
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_start_ignored;
    start = 1'b1;
    a = 8'h5A;
    b = 8'h3C;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = (c == 3 || c == 5);
      a = 8'h01;
      b = 8'h02;
      checks++;
      if (done !== (c == 9))
        $display("FAIL ignore_done c%0d: done=%b required %b", c, done, (c == 9));
      else passed++;
      if (c == 9) begin
        checks++;
        if (diff !== 8'h1E || borrow !== 1'b0)
          $display("FAIL ignore_result: diff/borrow=%h/%b required 1e/0", diff, borrow);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1;
    a = 8'h00;
    b = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      rst = (c == 4);
      if (c == 5) begin
        checks++;
        if ({busy, done, borrow, diff} !== 11'h0)
          $display("FAIL midrst: busy/done/borrow/diff=%b/%b/%b/%h required 0/0/0/00", busy, done, borrow, diff);
        else passed++;
      end else if (c > 5) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
          $display("FAIL midrst_idle c%0d: busy/done=%b/%b required 0/0", c, busy, done);
        else passed++;
      end
    end
    start = 1'b1;
    a = 8'h80;
    b = 8'h7F;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || diff !== 8'h01 || borrow !== 1'b0)
      $display("FAIL midrst_fresh: done/diff/borrow=%b/%h/%b required 1/01/0", done, diff, borrow);
    else passed++;
    tick();
  endtask

  task automatic test_random_sweep;
    int unsigned ra;
    int unsigned rb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [4:0]  ea5;
    logic [4:0]  eb5;
    logic [8:0]  got8;
    logic [5:0]  got5;
    logic [8:0]  exp8;
    logic [5:0]  exp5;
    int          dones8;
    int          dones5;
    int          overlap;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      ea = ra[7:0];
      eb = rb[7:0];
      ea5 = ra[12:8];
      eb5 = rb[12:8];
      if (n == 0) begin
        ea = 8'h00; eb = 8'hFF; ea5 = 5'h00; eb5 = 5'h1F;
      end else if (n == 1) begin
        ea = 8'hFF; eb = 8'h00; ea5 = 5'h1F; eb5 = 5'h00;
      end
      a = ea; b = eb; a5 = ea5; b5 = eb5;
      start = 1'b1;
      start5 = 1'b1;
      dones8 = 0; dones5 = 0; overlap = 0;
      got8 = '0; got5 = '0;
      for (int c = 1; c <= 9; c++) begin
        tick();
        start = 1'b0;
        start5 = 1'b0;
        a = 8'($urandom);
        a5 = 5'($urandom);
        if (done === 1'b1) begin
          dones8++;
          got8 = {borrow, diff};
        end
        if (done5 === 1'b1) begin
          dones5++;
          got5 = {borrow5, diff5};
        end
        if ((busy === 1'b1 && done === 1'b1) || (busy5 === 1'b1 && done5 === 1'b1))
          overlap++;
      end
      exp8 = {1'b0, ea} - {1'b0, eb};
      exp5 = {1'b0, ea5} - {1'b0, eb5};
      checks++;
      if (dones8 != 1) $display("FAIL sweep8_done n%0d: %0d pulses required 1", n, dones8);
      else passed++;
      checks++;
      if (got8 !== exp8) $display("FAIL sweep8 n%0d %h-%h: {borrow,diff}=%h required %h", n, ea, eb, got8, exp8);
      else passed++;
      checks++;
      if (dones5 != 1) $display("FAIL sweep5_done n%0d: %0d pulses required 1", n, dones5);
      else passed++;
      checks++;
      if (got5 !== exp5) $display("FAIL sweep5 n%0d %h-%h: {borrow,diff}=%h required %h", n, ea5, eb5, got5, exp5);
      else passed++;
      checks++;
      if (overlap != 0) $display("FAIL sweep_overlap n%0d: busy&done seen %0d times required 0", n, overlap);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start5 = 1'b0;
    a = '0;
    b = '0;
    a5 = '0;
    b5 = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_random_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, the subtract-direction companion of the team's adder cells.
- Computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake, so an FSM or lab top-level can sequence operations.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived localparam, not overridable).

Ports:
- clk     input   1      rising-edge clock
- rst     input   1      synchronous, active-high reset
- start   input   1      request a new subtraction; sampled on rising clk
- a       input   WIDTH  minuend; captured on accepted start
- b       input   WIDTH  subtrahend; captured on accepted start
- busy    output  1      high while bits are being processed
- done    output  1      one-cycle pulse when diff/borrow update
- diff    output  WIDTH  registered result a - b mod 2^WIDTH
- borrow  output  1      final borrow-out; 1 means unsigned a < b

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - rst wins over every other input in the same cycle.
- Reset values:
  - state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - Shift registers, counter and borrow flip-flop are all 0.
- FSM states IDLE, RUN, FIN:
  - IDLE: busy=0, done=0. start=1 gives the accept actions below, then goes to RUN. Otherwise stays in IDLE.
  - RUN: busy=1. Each edge processes one bit. After the WIDTH-th bit, goes to FIN. start is ignored.
  - FIN: lasts one cycle, busy=0, done=1. start=1 gives the accept actions below, then goes to RUN. Otherwise goes to IDLE.
- Accept actions:
  - sa<=a, sb<=b.
  - bff<=0 (borrow-in is 0).
  - cnt<=0.
  - Result shift register cleared.
- Bit cell, on bits sa[0], sb[0], bff:
  - d = sa[0] ^ sb[0] ^ bff.
  - bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bff).
- Each RUN edge:
  - sa and sb shift right by 1.
  - d is shifted into the MSB of the result register.
  - bff<=bout, cnt<=cnt+1.
- Completion edge (cnt==WIDTH-1 in RUN): diff<=final result register contents, borrow<=bout of the last bit.
- Latency:
  - start high in cycle 0.
  - busy high in cycles 1..WIDTH.
  - done high in cycle WIDTH+1.
  - diff/borrow are valid from cycle WIDTH+1.
- Output stability:
  - diff/borrow change only on a completion edge or on reset.
  - They hold between operations and during the next operation.
  - Intermediate bits are never visible.
- Boundary conditions:
  - start while busy: ignored; no restart, no effect on the result.
  - start in FIN: accepted. done=1 and the new capture occur in the same cycle, giving back-to-back throughput of one result per WIDTH+1 cycles.
  - Reset mid-RUN: abort; the next cycle is IDLE with all outputs 0 and no done pulse.
  - a==b gives diff=0, borrow=0. a<b gives two's-complement wrap with borrow=1.
  - a and b may change freely after the accept edge.

Decomposition:
- Shared package (lab_arith_pkg):
  - State enum typedef {IDLE, RUN, FIN}.
  - Default WIDTH constant.
- Sub-module full_subtractor:
  - Combinational bit cell with ports (output d, bout, input x, y, bin).
  - Gate-level structural, mirroring the adder cell style; instantiated once.
- Top level holds:
  - FSM, counter and shift registers.
  - Borrow flip-flop and output registers.

Test Plan:
1. WIDTH=8: a=8'h5A, b=8'h3C, start pulse at cycle 0 -> busy cycles 1..8; done at cycle 9 with diff=8'h1E, borrow=0.
2. a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1. Then a=8'h80, b=8'h7F -> diff=8'h01, borrow=0. Then a=b=8'hA5 -> diff=8'h00, borrow=0.
3. Start held high continuously, a/b changed every cycle -> only values present on accept edges are used. Each done is WIDTH+1 cycles after the prior accept; results match those captured operands.
4. start pulsed again in cycles 3 and 5 during RUN with different operands -> ignored; done at cycle 9 with the original result, and no extra done follows.
5. rst asserted at cycle 4 of RUN -> cycle 5 shows busy=0, done=0, diff=0, borrow=0. A fresh start afterwards gives the correct result.
6. Random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=5 -> {borrow,diff} == {a<b, (a-b) mod 2^WIDTH}. done fires exactly once per accepted start; busy and done are never high together.
